// File: rtl/tt_um_ota_readout.sv
// OTA comparator readout: counts comparator ones over a selectable window after
// a settling period and reports a density-scaled 8-bit result.
module tt_um_ota_readout #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned SW = $clog2(SETTLE_CYC + 2);
  localparam int unsigned CW = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CONV   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic          cmp_s1;
  logic          cmp;
  logic          start_q;
  logic          start_prev;
  logic          sync_valid;
  logic          armed;
  logic          start_edge_c;
  logic [1:0]    sel_q;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] conv_cnt;
  logic [CW-1:0] ones;
  logic [CW-1:0] ones_nx_c;
  logic [CW-1:0] conv_last_val_c;
  logic          settle_last_c;
  logic          conv_last_c;
  logic [8:0]    res9_c;
  logic [7:0]    result_c;
  logic [7:0]    result_q;
  logic          busy_q;
  logic          done_q;
  logic          fb_q;
  logic          unused_bits;

  // A start held through reset must be seen low once before an edge can count
  assign start_edge_c = start_q & ~start_prev & armed;

  // Window length minus one for the latched window select
  always_comb begin
    conv_last_val_c = 8'd15;
    case (sel_q)
      2'd0:    conv_last_val_c = 8'd15;
      2'd1:    conv_last_val_c = 8'd31;
      2'd2:    conv_last_val_c = 8'd63;
      default: conv_last_val_c = 8'd127;
    endcase
  end

  assign settle_last_c = (settle_cnt == SW'(SETTLE_CYC - 1));
  assign conv_last_c   = (conv_cnt == conv_last_val_c);

  // Count including the current cycle's comparator bit, scaled to full range
  always_comb begin
    ones_nx_c = ones;
    if (cmp && (ones != 8'hFF)) begin
      ones_nx_c = ones + 8'd1;
    end
    res9_c   = 9'(ones_nx_c) << (3'd4 - 3'(sel_q));
    result_c = res9_c[8] ? 8'hFF : res9_c[7:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start_edge_c) state_nx = ST_SETTLE;
      ST_SETTLE: if (settle_last_c) state_nx = ST_CONV;
      ST_CONV:   if (conv_last_c) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
    if (!ena) begin
      state_nx = ST_IDLE;
    end
  end

  // Input synchronizers and start edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_s1     <= 1'b0;
      cmp        <= 1'b0;
      start_q    <= 1'b0;
      start_prev <= 1'b0;
      sync_valid <= 1'b0;
      armed      <= 1'b0;
    end else begin
      cmp_s1     <= ui_in[0];
      cmp        <= cmp_s1;
      start_q    <= ui_in[1];
      start_prev <= start_q;
      sync_valid <= 1'b1;
      armed      <= armed | (sync_valid & ~start_q);
    end
  end

  // Conversion datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= 2'd0;
      settle_cnt <= '0;
      conv_cnt   <= '0;
      ones       <= '0;
      result_q   <= '0;
    end else begin
      settle_cnt <= (state == ST_SETTLE) ? settle_cnt + SW'(1) : '0;
      conv_cnt   <= (state == ST_CONV) ? conv_cnt + 8'd1 : '0;
      if ((state == ST_IDLE) && (state_nx == ST_SETTLE)) begin
        sel_q <= ui_in[3:2];
        ones  <= '0;
      end
      if (state == ST_CONV) begin
        ones <= ones_nx_c;
      end
      if ((state == ST_CONV) && (state_nx == ST_DONE)) begin
        result_q <= result_c;
      end
    end
  end

  // Status outputs, cleared immediately by a dropped enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fb_q   <= 1'b0;
    end else begin
      busy_q <= ena & ((state == ST_SETTLE) | (state == ST_CONV));
      done_q <= ena & (state == ST_DONE);
      fb_q   <= ena & (state == ST_CONV) & cmp;
    end
  end

  assign uo_out      = result_q;
  assign uio_out     = {5'b0, done_q, busy_q, fb_q};
  assign uio_oe      = 8'b0000_0111;
  assign unused_bits = ^{uio_in, ui_in[7:4]};

endmodule
